// File: rtl/tug_game_ctrl.sv
// rtl/tug_game_ctrl.sv - tug-of-war round, rope position and score controller
//
// Conditions the two raw player keys into single-cycle press events, moves a
// one-hot rope light, detects a win at either end, holds the winner display,
// re-centres the rope and ends the game at the score limit.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   key_l       raw left-player key (asynchronous to clk)
//   key_r       raw right-player key (asynchronous to clk)
//   lights      one-hot rope position, bit NUM_LIGHTS-1 leftmost; zero outside play
//   winner      2'b10 left won, 2'b01 right won, 2'b00 none
//   score_l     left player round wins
//   score_r     right player round wins
//   round_start one-cycle pulse when a new round begins
//   game_over   high once either score reaches SCORE_MAX
module tug_game_ctrl #(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_MAX   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_l,
  input  logic                  key_r,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [1:0]            winner,
  output logic [2:0]            score_l,
  output logic [2:0]            score_r,
  output logic                  round_start,
  output logic                  game_over
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [PW-1:0] CENTRE    = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] LAST      = PW'(NUM_LIGHTS - 1);
  localparam logic [2:0]    SMAX      = 3'(SCORE_MAX);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [CW-1:0] hold_cnt;

  // Synchronizer (s1, s2) plus delay flop (s3) per key.
  logic sl1, sl2, sl3;
  logic sr1, sr2, sr3;

  logic press_l, press_r;
  logic move_l, move_r;
  logic [2:0] score_l_inc, score_r_inc;

  function automatic logic [NUM_LIGHTS-1:0] onehot(input logic [PW-1:0] p);
    logic [NUM_LIGHTS-1:0] one;
    one = {{(NUM_LIGHTS-1){1'b0}}, 1'b1};
    return one << p;
  endfunction

  assign press_l = sl2 & ~sl3;
  assign press_r = sr2 & ~sr3;
  // Simultaneous presses cancel out.
  assign move_l  = press_l & ~press_r;
  assign move_r  = press_r & ~press_l;

  always_comb begin
    score_l_inc = (score_l < SMAX) ? score_l + 3'd1 : score_l;
    score_r_inc = (score_r < SMAX) ? score_r + 3'd1 : score_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLAY;
      pos         <= CENTRE;
      lights      <= onehot(CENTRE);
      winner      <= 2'b00;
      score_l     <= 3'd0;
      score_r     <= 3'd0;
      round_start <= 1'b0;
      game_over   <= 1'b0;
      hold_cnt    <= '0;
      sl1 <= 1'b0; sl2 <= 1'b0; sl3 <= 1'b0;
      sr1 <= 1'b0; sr2 <= 1'b0; sr3 <= 1'b0;
    end else begin
      // Edge detection keeps running in every state so a key held across
      // the end of a hold never looks like a fresh press.
      sl1 <= key_l; sl2 <= sl1; sl3 <= sl2;
      sr1 <= key_r; sr2 <= sr1; sr3 <= sr2;
      round_start <= 1'b0;

      case (state)
        PLAY: begin
          if (move_l) begin
            if (pos == LAST) begin
              lights  <= '0;
              winner  <= 2'b10;
              score_l <= score_l_inc;
              if (score_l_inc == SMAX) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state    <= HOLD;
                hold_cnt <= HOLD_LOAD;
              end
            end else begin
              pos    <= pos + 1'b1;
              lights <= onehot(pos + 1'b1);
            end
          end else if (move_r) begin
            if (pos == '0) begin
              lights  <= '0;
              winner  <= 2'b01;
              score_r <= score_r_inc;
              if (score_r_inc == SMAX) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state    <= HOLD;
                hold_cnt <= HOLD_LOAD;
              end
            end else begin
              pos    <= pos - 1'b1;
              lights <= onehot(pos - 1'b1);
            end
          end
        end

        HOLD: begin
          if (hold_cnt == '0) begin
            state       <= PLAY;
            pos         <= CENTRE;
            lights      <= onehot(CENTRE);
            winner      <= 2'b00;
            round_start <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        OVER: begin
          lights <= '0;
        end

        default: begin
          state  <= PLAY;
          pos    <= CENTRE;
          lights <= onehot(CENTRE);
        end
      endcase
    end
  end

endmodule
